adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

- Implements the responder side of the modular-ADC command/response stream that the audio-codec front end uses as an initiator: it accepts one channel command at a time and returns one 12-bit sample per command.
- Samples come from an external 8-channel SPI ADC (ADC128S022-class, 16-clock frames, address takes effect one frame later) instead of the on-chip ADC.
- Lets the FM transmitter's audio path run unchanged on boards without the hard ADC.

## Interface
- CLK_DIV, 25: SYS_CLK cycles per SCLK half-period (≥2); 25 gives 1 MHz SCLK at 50 MHz.
- SYS_CLK  in  1  sole clock.
- RESET_n  in  1  synchronous, active-low reset.
- CMD_VALID  in  1  command request.
- CMD_CHANNEL  in  5  requested channel; legal 0–7.
- CMD_SOP, CMD_EOP  in  1 each  accepted, ignored.
- CMD_READY  out  1  block can accept a command.
- RSP_VALID  out  1  single-cycle response strobe; no backpressure.
- RSP_CHANNEL  out  5  channel of the accepted command.
- RSP_DATA  out  12  sample, unsigned.
- RSP_SOP, RSP_EOP  out  1 each  equal to RSP_VALID.
- ADC_CS_N  out  1  SPI chip select, active low.
- ADC_SCLK  out  1  SPI clock, idle high.
- ADC_DIN  out  1  SPI data to the ADC.
- ADC_DOUT  in  1  SPI data from the ADC; synchronised with 2 flops inside the block.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, RESPOND.
- **IDLE**
  - CMD_READY=1.
  - Accept on CMD_VALID&&CMD_READY: latch channel; go to SETUP.
- **Illegal channel** (CMD_CHANNEL[4:3]≠0): no SPI frame. Go straight to RESPOND with RSP_DATA=0.
- **Frame contents**
  - 16 SCLK periods per frame, bit index k=0..15, MSB first.
  - ADC_DIN: ADD2..ADD0 on k=2,3,4; 0 on all other k.
  - ADC_DOUT: sampled on SCLK rising edges for k=4..15, giving D11..D0. Bits k=0..3 are discarded.
- **Address tracker**
  - 3-bit last-address register plus a valid flag; holds the address sent in the previous frame.
  - Hit (valid, address equals requested channel): one frame.
  - Miss: a priming frame (result discarded), then the data frame.
  - Updated after every frame.
- **RESPOND**: RSP_VALID=1 for one cycle with latched channel and data; then IDLE.
- **Outputs held between responses**: RSP_DATA and RSP_CHANNEL keep their last values.
- **Reset** (including mid-frame):
  - State → IDLE, ADC_CS_N=1, ADC_SCLK=1, ADC_DIN=0.
  - RSP_VALID=0, RSP_DATA=0, RSP_CHANNEL=0.
  - Tracker valid=0.
  - CMD_READY=0 while RESET_n=0.

## Timing
- **Acceptance**: T = acceptance cycle.
- **Frame start**: ADC_CS_N falls at T+1.
- **SETUP**: CLK_DIV cycles.
- **SHIFT**
  - SCLK falls (DIN changes) at the start of each bit.
  - SCLK rises CLK_DIV later; DOUT is sampled on that rising-edge cycle (after synchroniser delay, accounted for inside the block).
  - Lasts 32·CLK_DIV cycles.
- **HOLD**: SCLK high, CS_N low for CLK_DIV cycles. CS_N then rises, giving CS_N low for 34·CLK_DIV cycles.
- **Between frames**: CS_N high ≥CLK_DIV cycles.
- **Latency, acceptance → RSP_VALID**
  - Hit: 34·CLK_DIV+1 cycles.
  - Miss: 69·CLK_DIV+1 cycles.
  - Illegal channel: 2 cycles.
- **CMD_READY**: low from T+1 until the cycle after RSP_VALID. Back-to-back commands are therefore separated by ≥1 IDLE cycle.
- **Simultaneous events**: CMD_VALID during RESPOND is not accepted; it must be held until CMD_READY.

## Configuration
- Macro: ADC_SPI_OVERSAMPLE_EN.
- Defined:
  - Each legal command runs 4 data frames, after the priming frame if the tracker missed.
  - 14-bit accumulator; RSP_DATA = sum[13:2], truncated.
  - Hit latency 139·CLK_DIV+1 cycles; miss latency 174·CLK_DIV+1 cycles.
- Undefined: single data frame as above.

## Structure
- Package adc_spi_pkg holds:
  - FSM state enum.
  - Constants FRAME_BITS=16, ADDR_FIRST_BIT=2, DATA_FIRST_BIT=4.
  - Oversample count 4.
- Sub-module adc_spi_clkgen: CLK_DIV counter producing fall/rise strobes and bit index, enabled only during SHIFT.

## Test plan
- **Illegal channel**: CMD_CHANNEL=9 → RSP_VALID 2 cycles after acceptance, RSP_DATA=0, RSP_CHANNEL=9, no CS_N activity.
- **Miss then hit** (SPI model returns 12'hA5C for ch 3):
  - Command ch 3 after reset → two frames, DIN ADD=011 in both, RSP_DATA=0xA5C at 69·CLK_DIV+1.
  - Repeat ch 3 → one frame, RSP_DATA=0xA5C at 34·CLK_DIV+1.
- **Channel switch**: ch 3 then ch 5 (model ch5=0x123) → second command takes two frames, RSP_DATA=0x123, RSP_CHANNEL=5.
- **Reset mid-frame**:
  - Assert RESET_n=0 at bit 8 → next cycle CS_N=1, SCLK=1, CMD_READY=0.
  - After release, ch 3 takes two frames.
- **Oversample** (macro defined): model returns 100, 101, 102, 103 → RSP_DATA=101.
- **Protocol checker**:
  - CS_N low exactly 34·CLK_DIV cycles.
  - 16 rising SCLK edges per frame.
  - CMD_READY=0 throughout every frame.

Source files
------------

// File: rtl/adc_spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_spi_pkg : shared types and constants for the SPI ADC responder    |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package adc_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

  localparam int FRAME_BITS     = 16;
  localparam int ADDR_FIRST_BIT = 2;
  localparam int DATA_FIRST_BIT = 4;
  localparam int OVERSAMPLE     = 4;
  localparam int ACC_W          = 14;

  // Address bits ADD2..ADD0 occupy three consecutive frame bits, MSB first.
  function automatic logic din_for_bit(input logic [3:0] k, input logic [2:0] addr);
    case (k)
      4'(ADDR_FIRST_BIT):     return addr[2];
      4'(ADDR_FIRST_BIT + 1): return addr[1];
      4'(ADDR_FIRST_BIT + 2): return addr[0];
      default:                return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_spi_clkgen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_spi_clkgen : SCLK half-period divider with bit index; runs only   |
// |                  while enabled, otherwise held at the frame origin    |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module adc_spi_clkgen #(
  parameter int CLK_DIV = 25
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       en,
  output logic       fall_stb,
  output logic       rise_stb,
  output logic       last_stb,
  output logic [3:0] bit_idx
);
  import adc_spi_pkg::*;

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic [3:0]       r_bit;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (!reset_n || !en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
      if (r_phase) r_bit <= r_bit + 4'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Strobes fire on the last cycle of a half-period so the edge lands next cycle.
  assign rise_stb = en && w_wrap && !r_phase;
  assign fall_stb = en && w_wrap && r_phase;
  assign last_stb = fall_stb && (r_bit == 4'(FRAME_BITS - 1));
  assign bit_idx  = r_bit;

endmodule
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_spi_responder : command/response ADC responder backed by an       |
// |                     external 8-channel SPI ADC; ADC_SPI_OVERSAMPLE_EN |
// |                     averages 4 data frames per command                |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module adc_spi_responder #(
  parameter int CLK_DIV = 25
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [4:0]  cmd_channel,
  input  logic        cmd_sop,
  input  logic        cmd_eop,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [4:0]  rsp_channel,
  output logic [11:0] rsp_data,
  output logic        rsp_sop,
  output logic        rsp_eop,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout
);
  import adc_spi_pkg::*;

`ifdef ADC_SPI_OVERSAMPLE_EN
  localparam bit OVERSAMPLE_EN = 1'b1;
`else
  localparam bit OVERSAMPLE_EN = 1'b0;
`endif
  localparam int DATA_FRAMES = OVERSAMPLE_EN ? OVERSAMPLE : 1;
  localparam int CNT_W       = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_chan;
  logic             r_illegal, r_priming, r_gap, r_samp, r_ready;
  logic [2:0]       r_frames_left;
  logic [11:0]      r_shift;
  logic [ACC_W-1:0] r_acc;
  logic [2:0]       r_last_addr;
  logic             r_addr_valid;
  logic             r_dout_meta, r_dout_sync;
  logic             r_cs_n, r_sclk, r_din, r_rsp_valid;
  logic [4:0]       r_rsp_channel;
  logic [11:0]      r_rsp_data;

  logic             w_accept, w_illegal_cmd, w_hit;
  logic             w_fall, w_rise, w_last;
  logic [3:0]       w_bit;
  logic [ACC_W-1:0] w_acc_next;
  logic [11:0]      w_result;
  logic             w_unused;

  adc_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .en      (r_state == ST_SHIFT),
    .fall_stb(w_fall),
    .rise_stb(w_rise),
    .last_stb(w_last),
    .bit_idx (w_bit)
  );

  assign w_accept      = cmd_valid && r_ready;
  assign w_illegal_cmd = |cmd_channel[4:3];
  assign w_hit         = r_addr_valid && (r_last_addr == cmd_channel[2:0]);
  assign w_acc_next    = r_acc + (r_priming ? '0 : ACC_W'(r_shift));

`ifdef ADC_SPI_OVERSAMPLE_EN
  assign w_result = w_acc_next[ACC_W-1:2];
`else
  assign w_result = w_acc_next[11:0];
`endif

  assign w_unused = ^{cmd_sop, cmd_eop, w_acc_next};

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_dout_meta <= 1'b0;
      r_dout_sync <= 1'b0;
    end else begin
      r_dout_meta <= adc_dout;
      r_dout_sync <= r_dout_meta;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_chan        <= '0;
      r_illegal     <= 1'b0;
      r_priming     <= 1'b0;
      r_gap         <= 1'b0;
      r_samp        <= 1'b0;
      r_ready       <= 1'b0;
      r_frames_left <= '0;
      r_shift       <= '0;
      r_acc         <= '0;
      r_last_addr   <= '0;
      r_addr_valid  <= 1'b0;
      r_cs_n        <= 1'b1;
      r_sclk        <= 1'b1;
      r_din         <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_channel <= '0;
      r_rsp_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready       <= 1'b0;
            r_state       <= ST_SETUP;
            r_chan        <= cmd_channel;
            r_illegal     <= w_illegal_cmd;
            r_cs_n        <= w_illegal_cmd;
            r_priming     <= !w_hit;
            r_frames_left <= w_hit ? 3'(DATA_FRAMES) : 3'(DATA_FRAMES + 1);
            r_cnt         <= '0;
            r_gap         <= 1'b0;
            r_acc         <= '0;
          end
        end
        ST_SETUP: begin
          if (r_illegal) begin
            r_state       <= ST_RESPOND;
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_channel <= r_chan;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_sclk  <= 1'b0;
            r_din   <= din_for_bit(4'd0, r_chan[2:0]);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          // Sample one cycle after the rise strobe, when SCLK is high at the pin.
          r_samp <= w_rise && (w_bit >= 4'(DATA_FIRST_BIT));
          if (r_samp) r_shift <= {r_shift[10:0], r_dout_sync};
          if (w_rise) r_sclk <= 1'b1;
          if (w_last) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_din   <= 1'b0;
          end else if (w_fall) begin
            r_sclk <= 1'b0;
            r_din  <= din_for_bit(w_bit + 4'd1, r_chan[2:0]);
          end
        end
        ST_HOLD: begin
          if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!r_gap) begin
            r_cnt        <= '0;
            r_cs_n       <= 1'b1;
            r_last_addr  <= r_chan[2:0];
            r_addr_valid <= 1'b1;
            r_acc        <= w_acc_next;
            r_priming    <= 1'b0;
            if (r_frames_left == 3'd1) begin
              r_state       <= ST_RESPOND;
              r_rsp_valid   <= 1'b1;
              r_rsp_data    <= w_result;
              r_rsp_channel <= r_chan;
            end else begin
              r_frames_left <= r_frames_left - 3'd1;
              r_gap         <= 1'b1;
            end
          end else begin
            // CS_N has been high for a full half-period; open the next frame.
            r_cnt   <= '0;
            r_gap   <= 1'b0;
            r_cs_n  <= 1'b0;
            r_state <= ST_SETUP;
          end
        end
        ST_RESPOND: begin
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_sop     = r_rsp_valid;
  assign rsp_eop     = r_rsp_valid;
  assign rsp_channel = r_rsp_channel;
  assign rsp_data    = r_rsp_data;
  assign adc_cs_n    = r_cs_n;
  assign adc_sclk    = r_sclk;
  assign adc_din     = r_din;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc_spi_responder : self-checking bench with an SPI ADC model      |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_adc_spi_responder;

  localparam int D = 3;
`ifdef ADC_SPI_OVERSAMPLE_EN
  localparam int NDATA = 4;
`else
  localparam int NDATA = 1;
`endif

  logic        sys_clk = 1'b0;
  logic        reset_n, cmd_valid, cmd_sop, cmd_eop;
  logic [4:0]  cmd_channel;
  logic        cmd_ready, rsp_valid, rsp_sop, rsp_eop;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;
  logic        adc_cs_n, adc_sclk, adc_din;
  logic        adc_dout = 1'b0;

  adc_spi_responder #(.CLK_DIV(D)) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_channel(cmd_channel),
    .cmd_sop    (cmd_sop),
    .cmd_eop    (cmd_eop),
    .cmd_ready  (cmd_ready),
    .rsp_valid  (rsp_valid),
    .rsp_channel(rsp_channel),
    .rsp_data   (rsp_data),
    .rsp_sop    (rsp_sop),
    .rsp_eop    (rsp_eop),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_din    (adc_din),
    .adc_dout   (adc_dout)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge sys_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ADC model: address latched on rises, used next frame
  logic [11:0] adc_val [8];
  logic [11:0] ramp_q [$];
  logic [2:0]  frame_addr_q [$];
  logic [2:0]  adc_addr = 3'd0;
  logic [2:0]  new_addr = 3'd0;
  logic [11:0] word = 12'd0;
  logic [11:0] wtmp;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  bit          abort_ok = 1'b0;
  int          kf = 0, rises = 0, low_cnt = 0, ready_viol = 0;

  always @(negedge sys_clk) begin
    if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
      if (ramp_q.size() > 0) word = ramp_q.pop_front();
      else                   word = adc_val[adc_addr];
      kf = -1; rises = 0; low_cnt = 0; new_addr = 3'd0;
    end
    if (adc_cs_n === 1'b0) begin
      low_cnt++;
      if (cmd_ready !== 1'b0) ready_viol++;
      if (prev_sclk === 1'b1 && adc_sclk === 1'b0) begin
        kf++;
        if (kf >= 4 && kf < 16) begin
          wtmp = word << (kf - 4);
          adc_dout = wtmp[11];
        end else begin
          adc_dout = 1'b0;
        end
      end
      if (prev_sclk === 1'b0 && adc_sclk === 1'b1) begin
        case (rises)
          2: new_addr[2] = adc_din;
          3: new_addr[1] = adc_din;
          4: new_addr[0] = adc_din;
          default: ;
        endcase
        rises++;
      end
    end
    if (prev_cs === 1'b0 && adc_cs_n === 1'b1) begin
      if (!abort_ok) begin
        check("cs_low_cycles", low_cnt, 34 * D);
        check("sclk_rises", rises, 16);
        frame_addr_q.push_back(new_addr);
        adc_addr = new_addr;
      end
      adc_dout = 1'b0;
    end
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  // ---------------- reference tracker and command runner
  bit       m_valid = 1'b0;
  logic [2:0] m_last = 3'd0;

  task automatic run_cmd(input logic [4:0] ch, input logic [11:0] exp_data);
    int t0, nfr, exp_lat;
    bit ill, hit;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge sys_clk);
    if (cmd_ready !== 1'b1) begin
      check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    ill     = (ch[4:3] != 2'b00);
    hit     = m_valid && (m_last == ch[2:0]);
    nfr     = ill ? 0 : (hit ? NDATA : NDATA + 1);
    exp_lat = ill ? 2 : (35 * nfr - 1) * D + 1;
    frame_addr_q.delete();
    cmd_valid   = 1'b1;
    cmd_channel = ch;
    cmd_sop     = 1'b1;
    cmd_eop     = 1'b1;
    t0 = cyc;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    cmd_sop   = 1'b0;
    cmd_eop   = 1'b0;
    while (rsp_valid !== 1'b1 && (cyc - t0) < 200 * D + 50) @(negedge sys_clk);
    check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid === 1'b1) begin
      check("latency", cyc - t0, exp_lat);
      check("rsp_data", {20'd0, rsp_data}, {20'd0, exp_data});
      check("rsp_channel", {27'd0, rsp_channel}, {27'd0, ch});
      check("rsp_sop_eop", {30'd0, rsp_sop, rsp_eop}, 32'd3);
      @(negedge sys_clk);
      check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
      check("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
      check("rsp_data_held", {20'd0, rsp_data}, {20'd0, exp_data});
    end
    check("frame_count", frame_addr_q.size(), nfr);
    foreach (frame_addr_q[i]) check("frame_addr", {29'd0, frame_addr_q[i]}, {29'd0, ch[2:0]});
    if (!ill) begin
      m_valid = 1'b1;
      m_last  = ch[2:0];
    end
  endtask

  typedef struct {
    logic [4:0]  ch;
    logic [11:0] val;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rch;
    logic [11:0] rval;
    vecs[0] = '{5'd9,  12'h000, 12'h000};
    vecs[1] = '{5'd3,  12'hA5C, 12'hA5C};
    vecs[2] = '{5'd3,  12'hA5C, 12'hA5C};
    vecs[3] = '{5'd5,  12'h123, 12'h123};
    vecs[4] = '{5'd5,  12'h123, 12'h123};
    vecs[5] = '{5'd31, 12'h000, 12'h000};
    vecs[6] = '{5'd5,  12'h123, 12'h123};
    vecs[7] = '{5'd0,  12'h000, 12'h000};
    vecs[8] = '{5'd7,  12'hFFF, 12'hFFF};
    vecs[9] = '{5'd7,  12'hFFF, 12'hFFF};
    for (int i = 0; i < 8; i++) adc_val[i] = 12'(i * 16 + 1);

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_channel = 5'd0; cmd_sop = 1'b0; cmd_eop = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check("rst_sclk", {31'd0, adc_sclk}, 32'd1);
    check("rst_din", {31'd0, adc_din}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {20'd0, rsp_data}, 32'd0);
    check("rst_rsp_channel", {27'd0, rsp_channel}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ch[4:3] == 2'b00) adc_val[vecs[i].ch[2:0]] = vecs[i].val;
      run_cmd(vecs[i].ch, vecs[i].exp);
    end

`ifdef ADC_SPI_OVERSAMPLE_EN
    adc_val[2] = 12'h111;
    run_cmd(5'd2, 12'h111);
    ramp_q.push_back(12'd100);
    ramp_q.push_back(12'd101);
    ramp_q.push_back(12'd102);
    ramp_q.push_back(12'd103);
    run_cmd(5'd2, 12'd101);
`endif

    // Reset in the middle of a frame, then the tracker must re-prime.
    adc_val[3] = 12'hA5C;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge sys_clk);
    cmd_valid = 1'b1; cmd_channel = 5'd3;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 * D && !(kf == 8 && adc_cs_n === 1'b0); i++) @(negedge sys_clk);
    check("reached_bit8", kf, 8);
    abort_ok = 1'b1;
    reset_n  = 1'b0;
    @(negedge sys_clk);
    check("midrst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check("midrst_sclk", {31'd0, adc_sclk}, 32'd1);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(negedge sys_clk);
    reset_n  = 1'b1;
    abort_ok = 1'b0;
    m_valid  = 1'b0;
    run_cmd(5'd3, 12'hA5C);

    for (int n = 0; n < 16; n++) begin
      rch = ($urandom_range(0, 11) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(8, 31));
      rval = 12'($urandom);
      if (rch[4:3] == 2'b00) adc_val[rch[2:0]] = rval;
      run_cmd(rch, (rch[4:3] == 2'b00) ? rval : 12'h000);
    end

    check("ready_low_in_frames", ready_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
